riscv_mc_control: RTL and testbench

- Main control FSM for the multicycle RV32I core.
- Sequences instruction register, PC, memory port, ALU operand muxes, and the 3-input rd writeback mux (result_src) over several cycles per instruction.
- Decodes opcode and funct3, resolves branch conditions from ALU flags, and stalls on the memory ready handshake.
- Counts retired instructions and traps on illegal opcodes.

---
 rtl/riscv_mc_pkg.sv | 52 +++++
 rtl/riscv_mc_control_branch_cond.sv | 26 ++
 rtl/riscv_mc_control.sv | 177 +++++++++++++++++
 tb/tb_riscv_mc_control.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
package riscv_mc_pkg;

  // Control FSM states.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BRANCH   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  // Major opcodes recognised by the decoder.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // rd writeback mux select.
  localparam logic [1:0] RES_ALUOUT  = 2'b00;
  localparam logic [1:0] RES_MEMDATA = 2'b01;
  localparam logic [1:0] RES_ALURES  = 2'b10;

  // ALU operand A select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  // ALU operand B select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU operation class.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/riscv_mc_control_branch_cond.sv
// Branch condition resolution from funct3 and the ALU compare flags.
module branch_cond (
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       taken,
  output logic       bad_funct3
);

  // funct3 010/011 are not branch encodings and are flagged as bad.
  always_comb begin
    taken      = 1'b0;
    bad_funct3 = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: bad_funct3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Main control FSM of the multicycle RV32I core.
module riscv_mc_control
  import riscv_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic             mem_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             illegal_q;
  logic             retire;
  logic             br_taken, br_bad;

  branch_cond u_branch_cond (
    .funct3     (funct3),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .taken      (br_taken),
    .bad_funct3 (br_bad)
  );

  // Next-state selection; retire marks the transitions that complete an instruction.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXECR;
          OP_I, OP_LUI:      state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_MEMWRITE: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_ALUWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_JALR:     state_d = S_JAL;
      S_JAL:      state_d = S_ALUWB;
      S_BRANCH: begin
        if (br_bad) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // State, retired-instruction counter and sticky trap flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
  end

  // Datapath controls decoded from the current state; strobes are killed during reset.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        pc_write   = mem_ready;
        ir_write   = mem_ready;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURES;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR, S_JALR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_MEMDATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LUI) begin
          alu_src_a = SRCA_ZERO;
        end else begin
          alu_src_a = SRCA_RS1;
          alu_op    = ALUOP_FUNCT;
        end
      end
      S_ALUWB:    reg_write = 1'b1;
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_CMP;
        pc_write  = br_taken & ~br_bad;
      end
      default: ;
    endcase
    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Self-checking bench: per-instruction cycle scripts with randomized traffic.
module tb_riscv_mc_control;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011,
                         T_I = 7'b0010011, T_LUI = 7'b0110111, T_JAL = 7'b1101111,
                         T_JALR = 7'b1100111, T_BR = 7'b1100011;

  typedef struct packed {
    logic       pc_w, ir_w, adr, mem_w, reg_w;
    logic [1:0] res, a, b, op;
    logic       ill;
  } ctl_t;

  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic zero = 1'b0, lt = 1'b0, ltu = 1'b0, mem_ready = 1'b0;

  logic pc_write, ir_write, adr_src, mem_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [31:0] instret;

  logic w4_pc_write, w4_ir_write, w4_adr_src, w4_mem_write, w4_reg_write, w4_illegal;
  logic [1:0] w4_result_src, w4_alu_src_a, w4_alu_src_b, w4_alu_op;
  logic [3:0] instret4;

  int n_vec = 0, n_err = 0;
  int unsigned model_cnt = 0;

  always #5 clk = ~clk;

  riscv_mc_control u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .illegal(illegal),
    .instret(instret)
  );

  riscv_mc_control #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .zero(zero), .lt(lt), .ltu(ltu),
    .mem_ready(mem_ready), .pc_write(w4_pc_write), .ir_write(w4_ir_write),
    .adr_src(w4_adr_src), .mem_write(w4_mem_write), .reg_write(w4_reg_write),
    .result_src(w4_result_src), .alu_src_a(w4_alu_src_a), .alu_src_b(w4_alu_src_b),
    .alu_op(w4_alu_op), .illegal(w4_illegal), .instret(instret4)
  );

  function automatic ctl_t mk(input logic pcw, irw, adr, mw, rw, input logic [1:0] res, a, b, op,
                              input logic ill);
    ctl_t c;
    c = {pcw, irw, adr, mw, rw, res, a, b, op, ill};
    return c;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // One clock of a normal instruction: drive mem_ready, check everything, advance.
  task automatic cyc(input string tag, input ctl_t exp, input logic rdy, input bit retire);
    ctl_t act;
    mem_ready = rdy;
    @(negedge clk);
    act = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a,
           alu_src_b, alu_op, illegal};
    n_vec++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, act, exp);
    end
    n_vec++;
    assert (instret === model_cnt) else begin
      n_err++;
      $error("FAIL %s instret observed=%0d expected=%0d", tag, instret, model_cnt);
    end
    n_vec++;
    assert (instret4 === 4'(model_cnt)) else begin
      n_err++;
      $error("FAIL %s instret4 observed=%0d expected=%0d", tag, instret4, 4'(model_cnt));
    end
    @(posedge clk);
    #1;
    if (retire) model_cnt++;
  endtask

  // One clock with reset asserted: strobes must be dead regardless of where we were.
  task automatic rst_cyc(input string tag, input logic rdy);
    logic [3:0] strobes;
    mem_ready = rdy;
    rst = 1'b1;
    @(negedge clk);
    strobes = {pc_write, ir_write, mem_write, reg_write};
    n_vec++;
    assert (strobes === 4'b0000) else begin
      n_err++;
      $error("FAIL %s strobes observed=%b expected=0000", tag, strobes);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_cnt = 0;
    $display("reset %s", tag);
  endtask

  task automatic fetch(input string tag, input int waits);
    for (int i = 0; i < waits; i++) cyc(tag, mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b0, 0);
    cyc(tag, mk(1,1,0,0,0,2'b10,2'b00,2'b10,2'b00,0), 1'b1, 0);
  endtask

  // Plays one instruction from fetch to retirement (or trap and reset) and checks each cycle.
  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic z, input logic l, input logic lu,
                           input int fw, input int mw, input int trap_len);
    bit   trapped;
    logic cond, taken;
    opcode = op; funct3 = f3; zero = z; lt = l; ltu = lu;
    trapped = 0;
    fetch(tag, fw);
    cyc(tag, mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), rb(), 0);
    case (op)
      T_R: begin
        cyc(tag, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,0), rb(), 0);
        cyc(tag, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), rb(), 1);
      end
      T_I: begin
        cyc(tag, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,0), rb(), 0);
        cyc(tag, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), rb(), 1);
      end
      T_LUI: begin
        cyc(tag, mk(0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,0), rb(), 0);
        cyc(tag, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), rb(), 1);
      end
      T_LOAD: begin
        cyc(tag, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), rb(), 0);
        for (int i = 0; i < mw; i++) cyc(tag, mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 0);
        cyc(tag, mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,0), 1'b1, 0);
        cyc(tag, mk(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,0), rb(), 1);
      end
      T_STORE: begin
        cyc(tag, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), rb(), 0);
        for (int i = 0; i < mw; i++) cyc(tag, mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 0);
        cyc(tag, mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b1, 1);
      end
      T_JAL, T_JALR: begin
        if (op == T_JALR) cyc(tag, mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), rb(), 0);
        cyc(tag, mk(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,0), rb(), 0);
        cyc(tag, mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,0), rb(), 1);
      end
      T_BR: begin
        if (f3[2:1] == 2'b01) begin
          cyc(tag, mk(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0), rb(), 0);
          trapped = 1;
        end else begin
          cond  = (f3[2:1] == 2'b00) ? z : (f3[1] ? lu : l);
          taken = cond ^ f3[0];
          cyc(tag, mk(taken,0,0,0,0,2'b00,2'b10,2'b00,2'b01,0), rb(), 1);
        end
      end
      default: trapped = 1;
    endcase
    if (trapped) begin
      for (int i = 0; i < trap_len; i++) cyc(tag, mk(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,1), rb(), 0);
      rst_cyc(tag, rb());
    end
    $display("instr %-8s op=%b f3=%b fw=%0d mw=%0d instret_model=%0d", tag, op, f3, fw, mw, model_cnt);
  endtask

  initial begin
    logic [6:0] ops [0:9];
    logic [6:0] bad_ops [0:3];
    int         k;
    ops     = '{T_LOAD, T_STORE, T_R, T_I, T_LUI, T_JAL, T_JALR, T_BR, T_BR, T_R};
    bad_ops = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};

    // Initial reset
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_cyc("init", 1'b1);

    // Directed scenarios
    run_instr("add", T_R, 3'b000, 0, 0, 0, 0, 0, 0);
    run_instr("lw_wait", T_LOAD, 3'b010, 0, 0, 0, 0, 3, 0);
    run_instr("beq_z1", T_BR, 3'b000, 1, 0, 0, 0, 0, 0);
    run_instr("bne_z1", T_BR, 3'b001, 1, 0, 0, 0, 0, 0);
    run_instr("bltu_1", T_BR, 3'b110, 0, 0, 1, 0, 0, 0);
    run_instr("sw", T_STORE, 3'b010, 0, 0, 0, 2, 1, 0);
    run_instr("jalr", T_JALR, 3'b000, 0, 0, 0, 0, 0, 0);
    run_instr("lui", T_LUI, 3'b000, 0, 0, 0, 1, 0, 0);
    run_instr("trap0", 7'b0000000, 3'b000, 0, 0, 0, 0, 0, 10);
    run_instr("br_bad", T_BR, 3'b010, 0, 0, 0, 0, 0, 3);

    // Reset in the middle of a stalled store
    opcode = T_STORE; funct3 = 3'b010;
    fetch("sw_rst", 0);
    cyc("sw_rst", mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b1, 0);
    cyc("sw_rst", mk(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,0), 1'b1, 0);
    cyc("sw_rst", mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,0), 1'b0, 0);
    rst_cyc("sw_rst", 1'b0);
    fetch("sw_rst", 0);
    cyc("sw_rst", mk(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,0), 1'b1, 0);
    rst_cyc("sw_rst2", 1'b1);

    // Sixteen back-to-back addi: narrow counter wraps to 0
    for (int i = 0; i < 16; i++) run_instr("addi", T_I, 3'b000, 0, 0, 0, 0, 0, 0);
    n_vec++;
    assert (instret4 === 4'd0 && instret === 32'd16) else begin
      n_err++;
      $error("FAIL wrap instret4=%0d instret=%0d expected 0/16", instret4, instret);
    end

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      k = $urandom_range(0, 24);
      if (k < 10)
        run_instr("rnd", ops[k], 3'($urandom), rb(), rb(), rb(),
                  $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(1, 4));
      else if (k < 23)
        run_instr("rnd", ops[k % 10], 3'($urandom), rb(), rb(), rb(), 0, 0, 2);
      else
        run_instr("rnd_bad", bad_ops[$urandom_range(0, 3)], 3'($urandom), rb(), rb(), rb(),
                  $urandom_range(0, 2), 0, $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
